// File: rtl/trig_capture_pkg.sv
// Shared defaults for the trigger event capture block.
package trig_capture_pkg;

    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned SEQ_W     = 8;

endpackage

// File: rtl/trig_capture_ch.sv
// One event channel: rising-edge detect, sticky pending flag,
// saturating occurrence counter and sticky overflow flag.
module trig_capture_ch
    import trig_capture_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             ev_in,
    input  logic             ack,
    input  logic             clear_all,
    output logic             pending,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic ev_prev;
    logic rise;
    logic clear;

    assign rise  = ev_in & ~ev_prev;
    assign clear = ack | clear_all;

    // Edge history and channel state; a clear coinciding with a rise
    // restarts the channel at one event so the new rise is kept.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ev_prev  <= 1'b0;
            pending  <= 1'b0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            ev_prev <= ev_in;
            if (clear) begin
                overflow <= 1'b0;
                pending  <= rise;
                count    <= rise ? CNT_W'(1) : '0;
            end else if (rise) begin
                pending <= 1'b1;
                if (count == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/trig_event_capture.sv
// Multi-channel trigger event capture with snapshot registers.
module trig_event_capture
    import trig_capture_pkg::*;
#(
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       ev_in,
    input  logic [N_CH-1:0]       ack,
    input  logic                  snap,
    input  logic                  snap_clear,
    output logic [N_CH-1:0]       pending,
    output logic [N_CH-1:0]       overflow,
    output logic                  any_pending,
    output logic [N_CH-1:0]       snap_pending,
    output logic [N_CH-1:0]       snap_overflow,
    output logic [N_CH*CNT_W-1:0] snap_count,
    output logic [SEQ_W-1:0]      snap_seq
);

    logic [N_CH*CNT_W-1:0] count;
    logic                  clear_all;

    assign clear_all   = snap & snap_clear;
    assign any_pending = |pending;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        trig_capture_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .sys_clk  (sys_clk),
            .reset    (reset),
            .ev_in    (ev_in[i]),
            .ack      (ack[i]),
            .clear_all(clear_all),
            .pending  (pending[i]),
            .overflow (overflow[i]),
            .count    (count[i*CNT_W +: CNT_W])
        );
    end

    // Snapshot captures channel state as it stood before this edge.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            snap_pending  <= '0;
            snap_overflow <= '0;
            snap_count    <= '0;
            snap_seq      <= '0;
        end else if (snap) begin
            snap_pending  <= pending;
            snap_overflow <= overflow;
            snap_count    <= count;
            snap_seq      <= snap_seq + SEQ_W'(1);
        end
    end

endmodule

// File: doc/trig_event_capture.md
TRIG_EVENT_CAPTURE -- requirements
Module: trig_event_capture

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of event channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8: per-channel occurrence counter width (2..16).
REQ-003 SHALL have port sys_clk, input, 1: sole clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ev_in, input, N_CH: event levels/pulses, sys_clk domain, e.g. count-equals flags.
REQ-006 SHALL have port ack, input, N_CH: one-cycle per-channel clear pulses, e.g. from a host trigger-in.
REQ-007 SHALL have port snap, input, 1: one-cycle snapshot request.
REQ-008 SHALL have port snap_clear, input, 1: level; when high, snap also clears all channels.
REQ-009 SHALL have port pending, output, N_CH: sticky per-channel event flags.
REQ-010 SHALL have port overflow, output, N_CH: sticky per-channel counter-saturation flags.
REQ-011 SHALL have port any_pending, output, 1: OR of pending.
REQ-012 SHALL have port snap_pending, output, N_CH: pending captured at the last snap.
REQ-013 SHALL have port snap_overflow, output, N_CH: overflow captured at the last snap.
REQ-014 SHALL have port snap_count, output, N_CH*CNT_W: counters captured at the last snap; channel i in bits [i*CNT_W +: CNT_W].
REQ-015 SHALL have port snap_seq, output, 8: snapshot sequence number.

Function
REQ-016 SHALL detect rise[i] = ev_in[i] & ~ev_prev[i], with ev_prev registered each cycle; a level held high counts once.
REQ-017 SHALL set pending[i] and increment count[i] at the same edge that first samples ev_in[i] high (1-cycle latency to output).
REQ-018 SHALL saturate count[i] at 2^CNT_W-1; a rise at saturation SHALL set overflow[i] and leave count unchanged.
REQ-019 SHALL, on ack[i], clear pending[i], overflow[i] and count[i] to 0.
REQ-020 SHALL, on ack[i] coincident with rise[i], clear overflow[i] and leave pending[i]=1, count[i]=1 (new event never lost).
REQ-021 SHALL, on snap, copy pending, overflow and all counters into the snap_* registers (values before this edge's updates), and increment snap_seq modulo 256.
REQ-022 SHALL, on snap with snap_clear=1, clear every channel as in REQ-019/REQ-020 in the same cycle; events rising in that cycle appear in the live state only, not the snapshot.
REQ-023 SHALL leave snap_* and snap_seq unchanged when snap=0; snap_clear alone SHALL have no effect.
REQ-024 SHALL treat simultaneous snap and ack[i] as: snapshot takes pre-ack values, then the ack applies.
REQ-025 SHALL drive any_pending combinationally from the registered pending vector.

Reset
REQ-026 SHALL, on reset, set pending, overflow, counters, snap_pending, snap_overflow, snap_count, snap_seq and ev_prev to 0.
REQ-027 SHALL give reset priority over all inputs; ev_in high on the first post-reset cycle SHALL register as a rise.

Structure
REQ-028 SHALL place default N_CH, CNT_W and the snap_seq width in shared package trig_capture_pkg.
REQ-029 SHALL implement one channel (edge detect, pending, counter, overflow) in sub-module trig_capture_ch, instantiated N_CH times by generate.
REQ-030 SHALL keep snapshot registers and snap_seq in the top level.

Verification
REQ-031 SHALL cover: ev_in[0] high for 10 cycles -> pending[0]=1 one cycle later, count[0]=1, other channels 0.
REQ-032 SHALL cover: 300 single-cycle pulses on ch1 (CNT_W=8) -> count[1]=255, overflow[1]=1; ack[1] -> all ch1 state 0.
REQ-033 SHALL cover: ack[2] in the same cycle as an ev_in[2] rise -> pending[2]=1, count[2]=1, overflow[2]=0.
REQ-034 SHALL cover: counts {3,0,5,1}, snap with snap_clear=1 while ch3 rises -> snap_count={3,0,5,1}, snap_seq=1, live count[3]=1, others 0.
REQ-035 SHALL cover: reset asserted mid-stream with ev_in=4'b1111 held high -> all outputs 0 during reset; the cycle after release, pending=4'b1111, counts=1.
